// File: rtl/mpu_alu_pkg.sv
// mpu_alu_pkg: shared definitions for the mpu_alu issue/writeback stage.
//   - bit positions of the fields inside the 32-bit instruction word
//   - ALU opcode constants
//   - issue FSM state encoding
//   - lane helpers: lane_mask(size, sel) and lane_valid(size, sel)
package mpu_alu_pkg;

    // Field LSB positions inside in_inst; op and size are 4 and 2 bits, all others 3 bits.
    localparam int unsigned OP_LSB   = 28;
    localparam int unsigned SIZE_LSB = 26;
    localparam int unsigned R0_LSB   = 23;
    localparam int unsigned S0_LSB   = 20;
    localparam int unsigned R1_LSB   = 17;
    localparam int unsigned S1_LSB   = 14;
    localparam int unsigned R2_LSB   = 11;
    localparam int unsigned S2_LSB   = 8;
    localparam int unsigned RD_LSB   = 5;
    localparam int unsigned SRES_LSB = 2;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_MASK = 4'd1;
    localparam logic [3:0] OP_CMP  = 4'd2;
    localparam logic [3:0] OP_LT   = 4'd3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRead = 2'd1,
        StExec = 2'd2,
        StWb   = 2'd3
    } issue_state_t;

    // W ones (W = 8 << size) placed at bit offset sel*W. Out-of-range lanes
    // may shift the ones off the top; callers gate with lane_valid.
    function automatic logic [63:0] lane_mask(input logic [1:0] size, input logic [2:0] sel);
        logic [63:0] base;
        int unsigned w;
        int unsigned off;
        case (size)
            2'd0:    base = 64'h0000_0000_0000_00FF;
            2'd1:    base = 64'h0000_0000_0000_FFFF;
            2'd2:    base = 64'h0000_0000_FFFF_FFFF;
            default: base = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        w   = 32'd8 << size;
        off = 32'(sel) * w;
        return base << off;
    endfunction

    // A lane exists iff sel < 8 >> size.
    function automatic logic lane_valid(input logic [1:0] size, input logic [2:0] sel);
        return (4'(sel) < (4'd8 >> size));
    endfunction

endpackage

// File: rtl/mpu_alu_regfile.sv
// mpu_alu_regfile: 8 x 64-bit register file.
//   clk, rst             clock and synchronous active-high reset
//   we, waddr, wdata,    single bit-masked write port; bits set in wmask
//   wmask                take wdata, the others keep their old value
//   raddr0..2 / rdata0..2 combinational operand reads
//   dbg_addr / dbg_data  combinational debug read
// With CLEAR_ON_RESET = 1 every register is zeroed while rst is high.
module mpu_alu_regfile #(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [2:0]  waddr,
    input  logic [63:0] wdata,
    input  logic [63:0] wmask,
    input  logic [2:0]  raddr0,
    input  logic [2:0]  raddr1,
    input  logic [2:0]  raddr2,
    input  logic [2:0]  dbg_addr,
    output logic [63:0] rdata0,
    output logic [63:0] rdata1,
    output logic [63:0] rdata2,
    output logic [63:0] dbg_data
);

    logic [63:0] mem [8];

    always_ff @(posedge clk) begin
        if (rst && CLEAR_ON_RESET) begin
            for (int i = 0; i < 8; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
        end
    end

    assign rdata0   = mem[raddr0];
    assign rdata1   = mem[raddr1];
    assign rdata2   = mem[raddr2];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/mpu_alu_issue.sv
// mpu_alu_issue: issue/writeback stage around the combinational mpu_alu.
//   sys_clk, sys_rst           clock, synchronous active-high reset
//   in_valid/in_ready/in_inst  instruction handshake (one per 4 cycles)
//   ld_en/ld_addr/ld_data      host register load, honoured only when idle
//   dbg_addr/dbg_data          combinational register read-back
//   alu_op..alu_sres           registered operands/controls to mpu_alu
//   alu_res/alu_flags          results from mpu_alu, sampled in EXEC
//   flags                      architectural flags register
//   done/err                   writeback pulse; err flags an out-of-range sres lane
// Sequence: IDLE (accept) -> READ (load ALU inputs) -> EXEC (capture result)
// -> WB (merge lane into rd, update flags) -> IDLE.
module mpu_alu_issue
    import mpu_alu_pkg::*;
#(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic        ld_en,
    input  logic [2:0]  ld_addr,
    input  logic [63:0] ld_data,
    input  logic [2:0]  dbg_addr,
    output logic [63:0] dbg_data,
    output logic [3:0]  alu_op,
    output logic [1:0]  alu_size,
    output logic [63:0] alu_o0,
    output logic [63:0] alu_o1,
    output logic [63:0] alu_o2,
    output logic [2:0]  alu_s0,
    output logic [2:0]  alu_s1,
    output logic [2:0]  alu_s2,
    output logic [2:0]  alu_sres,
    input  logic [63:0] alu_res,
    input  logic [7:0]  alu_flags,
    output logic [7:0]  flags,
    output logic        done,
    output logic        err
);

    issue_state_t state, state_next;

    // Decoded instruction, held from accept until writeback
    logic [3:0]  op_l;
    logic [1:0]  size_l;
    logic [2:0]  r0_l, s0_l, r1_l, s1_l, r2_l, s2_l, rd_l, sres_l;

    logic [63:0] res_hold;
    logic [7:0]  flags_hold;

    logic [63:0] rdata0, rdata1, rdata2;
    logic        we;
    logic [2:0]  waddr;
    logic [63:0] wdata, wmask;
    logic        lane_ok, wb_ok, accept;

    logic unused_inst_bits;
    assign unused_inst_bits = ^in_inst[1:0];

    assign lane_ok = lane_valid(size_l, sres_l);
    assign wb_ok   = (op_l != OP_NOP) && lane_ok;
    assign accept  = in_valid && in_ready;

    mpu_alu_regfile #(
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_regfile (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .we       (we && !sys_rst),
        .waddr    (waddr),
        .wdata    (wdata),
        .wmask    (wmask),
        .raddr0   (r0_l),
        .raddr1   (r1_l),
        .raddr2   (r2_l),
        .dbg_addr (dbg_addr),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshake, and the shared write port. Host load and
    // writeback use the same port; they never collide since they live in
    // different states.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        we         = 1'b0;
        waddr      = ld_addr;
        wdata      = ld_data;
        wmask      = '1;
        case (state)
            StIdle: begin
                in_ready = !ld_en;
                if (ld_en) begin
                    we = 1'b1;
                end else if (in_valid) begin
                    state_next = StRead;
                end
            end
            StRead: state_next = StExec;
            StExec: state_next = StWb;
            StWb: begin
                done       = 1'b1;
                err        = !lane_ok;
                state_next = StIdle;
                if (wb_ok) begin
                    we    = 1'b1;
                    waddr = rd_l;
                    wdata = res_hold;
                    wmask = lane_mask(size_l, sres_l);
                end
            end
            default: state_next = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            op_l       <= '0;
            size_l     <= '0;
            r0_l       <= '0;
            s0_l       <= '0;
            r1_l       <= '0;
            s1_l       <= '0;
            r2_l       <= '0;
            s2_l       <= '0;
            rd_l       <= '0;
            sres_l     <= '0;
            alu_op     <= '0;
            alu_size   <= '0;
            alu_o0     <= '0;
            alu_o1     <= '0;
            alu_o2     <= '0;
            alu_s0     <= '0;
            alu_s1     <= '0;
            alu_s2     <= '0;
            alu_sres   <= '0;
            res_hold   <= '0;
            flags_hold <= '0;
            flags      <= '0;
        end else begin
            if (state == StIdle && accept) begin
                op_l   <= in_inst[OP_LSB +: 4];
                size_l <= in_inst[SIZE_LSB +: 2];
                r0_l   <= in_inst[R0_LSB +: 3];
                s0_l   <= in_inst[S0_LSB +: 3];
                r1_l   <= in_inst[R1_LSB +: 3];
                s1_l   <= in_inst[S1_LSB +: 3];
                r2_l   <= in_inst[R2_LSB +: 3];
                s2_l   <= in_inst[S2_LSB +: 3];
                rd_l   <= in_inst[RD_LSB +: 3];
                sres_l <= in_inst[SRES_LSB +: 3];
            end
            if (state == StRead) begin
                alu_o0   <= rdata0;
                alu_o1   <= rdata1;
                alu_o2   <= rdata2;
                alu_op   <= op_l;
                alu_size <= size_l;
                alu_s0   <= s0_l;
                alu_s1   <= s1_l;
                alu_s2   <= s2_l;
                alu_sres <= sres_l;
            end
            if (state == StExec) begin
                res_hold   <= alu_res;
                flags_hold <= alu_flags;
            end
            if (state == StWb && wb_ok) begin
                flags <= flags_hold;
            end
        end
    end

endmodule

// File: tb/tb_mpu_alu_issue.sv
// Bench for mpu_alu_issue. The ALU is a stub whose res/flags the stimulus
// sets. Issued instructions push their expected err/flags and accept cycle
// into a scoreboard; the monitor pops on every done pulse.
module tb_mpu_alu_issue;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [63:0] ld_data;
    logic [2:0]  dbg_addr;
    logic [63:0] dbg_data;
    logic [3:0]  alu_op;
    logic [1:0]  alu_size;
    logic [63:0] alu_o0, alu_o1, alu_o2;
    logic [2:0]  alu_s0, alu_s1, alu_s2, alu_sres;
    logic [63:0] stub_res;
    logic [7:0]  stub_flags;
    logic [7:0]  flags;
    logic        done;
    logic        err;

    mpu_alu_issue #(
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .alu_op    (alu_op),
        .alu_size  (alu_size),
        .alu_o0    (alu_o0),
        .alu_o1    (alu_o1),
        .alu_o2    (alu_o2),
        .alu_s0    (alu_s0),
        .alu_s1    (alu_s1),
        .alu_s2    (alu_s2),
        .alu_sres  (alu_sres),
        .alu_res   (stub_res),
        .alu_flags (stub_flags),
        .flags     (flags),
        .done      (done),
        .err       (err)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_miss = 0;

    typedef struct {
        int         cyc;
        logic       err;
        logic [7:0] flags;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [1:0] size,
                                       input logic [2:0] r0, input logic [2:0] r1,
                                       input logic [2:0] r2, input logic [2:0] rd,
                                       input logic [2:0] sres);
        return {op, size, r0, 3'd0, r1, 3'd1, r2, 3'd2, rd, sres, 2'b00};
    endfunction

    // Monitor: on done, check latency and err; one cycle later check flags.
    logic       chk_pending = 1'b0;
    logic [7:0] chk_flags;
    always @(negedge sys_clk) begin
        exp_t e;
        if (chk_pending) begin
            chk("flags_after_wb", 64'(flags), 64'(chk_flags));
            chk_pending = 1'b0;
        end
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_done: got done=1 expected no writeback at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_latency", 64'(cyc), 64'(e.cyc + 3));
                chk("err_with_done", 64'(err), 64'(e.err));
                chk_pending = 1'b1;
                chk_flags   = e.flags;
            end
        end else if (err === 1'b1) begin
            n_vec++;
            n_miss++;
            $display("FAIL err_without_done: got err=1 expected 0 at cycle %0d", cyc);
        end
    end

    task automatic ld(input logic [2:0] a, input logic [63:0] d);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge sys_clk);
        #1 ld_en = 1'b0;
    endtask

    // Present an instruction until accepted; returns #1 after the accept edge.
    task automatic start(input logic [31:0] inst, input bit push,
                         input logic e_err, input logic [7:0] e_flags);
        bit ok = 0;
        in_valid = 1'b1;
        in_inst = inst;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (in_ready === 1'b1) begin
                ok = 1;
                if (push) sb.push_back('{cyc: cyc, err: e_err, flags: e_flags});
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_miss++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 20 cycles");
        end
        @(posedge sys_clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic finish_op();
        repeat (3) @(posedge sys_clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] inst, input logic e_err, input logic [7:0] e_flags);
        start(inst, 1'b1, e_err, e_flags);
        finish_op();
    endtask

    task automatic rd_reg(input string name, input logic [2:0] a, input logic [63:0] exp);
        dbg_addr = a;
        #1 chk(name, dbg_data, exp);
    endtask

    initial begin
        sys_rst = 1'b1;
        in_valid = 1'b0;
        in_inst = '0;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        dbg_addr = '0;
        stub_res = '0;
        stub_flags = '0;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;

        // Reset state
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_alu_o0", alu_o0, 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'd0);
        for (int i = 0; i < 8; i++) rd_reg("rst_reg", 3'(i), 64'd0);

        // Byte lane 1 merge
        ld(3'd1, 64'h0011_2233_4455_6677);
        stub_res = 64'hFFFF_FFFF_FFFF_FFFF;
        stub_flags = 8'hA5;
        issue(mk(4'd1, 2'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1), 1'b0, 8'hA5);
        rd_reg("byte_lane1", 3'd1, 64'h0011_2233_4455_FF77);

        // Out-of-range lane: size=2, sres=2
        stub_flags = 8'h11;
        issue(mk(4'd1, 2'd2, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2), 1'b1, 8'hA5);
        rd_reg("bad_lane_reg", 3'd1, 64'h0011_2233_4455_FF77);

        // size=3 full-width lane 0 valid, lane 1 invalid
        ld(3'd4, 64'h123);
        stub_res = 64'hDEAD_BEEF_CAFE_F00D;
        stub_flags = 8'h42;
        issue(mk(4'd3, 2'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd0), 1'b0, 8'h42);
        rd_reg("dword_lane0", 3'd4, 64'hDEAD_BEEF_CAFE_F00D);
        stub_res = 64'h0;
        stub_flags = 8'h99;
        issue(mk(4'd3, 2'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd1), 1'b1, 8'h42);
        rd_reg("dword_lane1_bad", 3'd4, 64'hDEAD_BEEF_CAFE_F00D);

        // Top halfword lane: size=1, sres=3
        ld(3'd5, 64'h0123_4567_89AB_CDEF);
        stub_res = 64'h1111_2222_3333_4444;
        stub_flags = 8'h5A;
        issue(mk(4'd9, 2'd1, 3'd5, 3'd0, 3'd1, 3'd5, 3'd3), 1'b0, 8'h5A);
        rd_reg("half_lane3", 3'd5, 64'h1111_4567_89AB_CDEF);

        // NOP leaves register and flags alone
        ld(3'd3, 64'h5);
        stub_res = 64'hFFFF_FFFF_FFFF_FFFF;
        stub_flags = 8'h77;
        issue(mk(4'd0, 2'd0, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0), 1'b0, 8'h5A);
        rd_reg("nop_reg", 3'd3, 64'h5);

        // Load and issue together: load wins, instruction accepted next cycle
        ld_en = 1'b1;
        ld_addr = 3'd6;
        ld_data = 64'hABCD;
        in_valid = 1'b1;
        in_inst = mk(4'd1, 2'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd0);
        stub_res = 64'h99;
        stub_flags = 8'h66;
        @(negedge sys_clk);
        chk("ld_blocks_ready", 64'(in_ready), 64'd0);
        @(posedge sys_clk);
        #1 ld_en = 1'b0;
        rd_reg("ld_priority", 3'd6, 64'hABCD);
        @(negedge sys_clk);
        chk("ready_after_ld", 64'(in_ready), 64'd1);
        if (in_ready === 1'b1) sb.push_back('{cyc: cyc, err: 1'b0, flags: 8'h66});
        @(posedge sys_clk);
        #1 in_valid = 1'b0;
        @(posedge sys_clk);
        #1 ld_en = 1'b1;              // now in EXEC: load must be ignored
        ld_addr = 3'd7;
        ld_data = 64'hFFFF;
        @(posedge sys_clk);
        #1 ld_en = 1'b0;
        @(posedge sys_clk);
        #1;
        rd_reg("wb_after_ld", 3'd6, 64'hAB99);
        rd_reg("ld_in_exec_ignored", 3'd7, 64'd0);

        // Operands presented in EXEC
        ld(3'd0, 64'h55);
        ld(3'd1, 64'h55);
        ld(3'd2, 64'hFF);
        stub_res = 64'hAA;
        stub_flags = 8'h3C;
        start(mk(4'd2, 2'd0, 3'd0, 3'd1, 3'd2, 3'd7, 3'd0), 1'b1, 1'b0, 8'h3C);
        @(posedge sys_clk);
        #1;
        chk("exec_o0", alu_o0, 64'h55);
        chk("exec_o1", alu_o1, 64'h55);
        chk("exec_o2", alu_o2, 64'hFF);
        chk("exec_op", 64'(alu_op), 64'd2);
        chk("exec_s2", 64'(alu_s2), 64'd2);
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        rd_reg("cmp_wb", 3'd7, 64'hAA);

        // Reset during EXEC drops the instruction
        stub_res = 64'hFFFF_FFFF_FFFF_FFFF;
        stub_flags = 8'h81;
        start(mk(4'd1, 2'd3, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0), 1'b0, 1'b0, 8'h00);
        @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_flags", 64'(flags), 64'd0);
        chk("midrst_alu_o0", alu_o0, 64'd0);
        for (int i = 0; i < 8; i++) rd_reg("midrst_reg", 3'(i), 64'd0);
        repeat (5) @(posedge sys_clk);
        #1;
        chk("midrst_no_late_flags", 64'(flags), 64'd0);
        rd_reg("midrst_no_late_wb", 3'd2, 64'd0);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
